i_decode: RTL and testbench

I_DECODE -- requirements
Module: i_decode

---
 rtl/i_decode_pkg.sv | 66 ++++++
 rtl/regfile.sv | 37 +++
 rtl/i_decode.sv | 80 ++++++++
 tb/tb_i_decode.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/i_decode_pkg.sv
// Shared constants, control-field layout and main-control decode for the ID stage.
package i_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;
  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUSRC   = 0;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } ctrl_t;

  // Unrecognised opcodes fall through to an all-zero bubble.
  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.wb[WB_REGWRITE]               = 1'b1;
        c.ex[EX_REGDST]                 = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_FUNCT;
      end
      OP_LW: begin
        c.wb[WB_REGWRITE]               = 1'b1;
        c.wb[WB_MEMTOREG]               = 1'b1;
        c.m[M_MEMREAD]                  = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_ADD;
        c.ex[EX_ALUSRC]                 = 1'b1;
      end
      OP_SW: begin
        c.m[M_MEMWRITE]                 = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_ADD;
        c.ex[EX_ALUSRC]                 = 1'b1;
      end
      OP_BEQ: begin
        c.m[M_BRANCH]                   = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_SUB;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32-entry 2R1W register file, register 0 hardwired to zero.
// Define I_DECODE_WB_BYPASS_EN to forward a same-cycle write to the read ports.
module regfile import i_decode_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        rd_addr_a,
  input  logic [4:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [32];

  // Reset wins over a coincident write-back, which is simply dropped.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != 5'd0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_a = (rd_addr_a == 5'd0) ? '0 : regs[rd_addr_a];
    rd_data_b = (rd_addr_b == 5'd0) ? '0 : regs[rd_addr_b];
`ifdef I_DECODE_WB_BYPASS_EN
    if (wr_en && (wr_addr != 5'd0) && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
    if (wr_en && (wr_addr != 5'd0) && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
`endif
  end

endmodule

// File: rtl/i_decode.sv
// ID stage: main-control decode, load-use hazard detection and the ID/EX register.
// Optional macro I_DECODE_WB_BYPASS_EN enables write-through in the register file.
module i_decode import i_decode_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       IF_ID_IR,
  input  logic [DATA_W-1:0] IF_ID_NPC,
  input  logic              EX_MEM_PCSrc,
  input  logic              MEM_WB_RegWrite,
  input  logic [4:0]        MEM_WB_WriteReg,
  input  logic [DATA_W-1:0] MEM_WB_WriteData,
  output logic [DATA_W-1:0] ID_EX_NPC,
  output logic [DATA_W-1:0] ID_EX_A,
  output logic [DATA_W-1:0] ID_EX_B,
  output logic [DATA_W-1:0] ID_EX_Imm,
  output logic [4:0]        ID_EX_rt,
  output logic [4:0]        ID_EX_rd,
  output logic [WB_W-1:0]   ID_EX_WB,
  output logic [M_W-1:0]    ID_EX_M,
  output logic [EX_W-1:0]   ID_EX_EX,
  output logic              stall
);

  logic [5:0]        opcode;
  logic [4:0]        rs, rt, rd;
  logic [DATA_W-1:0] rs_data, rt_data, imm_ext;
  ctrl_t             dec_ctrl;
  logic              bubble;

  assign opcode   = IF_ID_IR[31:26];
  assign rs       = IF_ID_IR[25:21];
  assign rt       = IF_ID_IR[20:16];
  assign rd       = IF_ID_IR[15:11];
  assign imm_ext  = {{(DATA_W-16){IF_ID_IR[15]}}, IF_ID_IR[15:0]};
  assign dec_ctrl = decode_ctrl(opcode);

  regfile #(.DATA_W(DATA_W)) u_regfile (
    .clock     (clock),
    .reset     (reset),
    .rd_addr_a (rs),
    .rd_addr_b (rt),
    .rd_data_a (rs_data),
    .rd_data_b (rt_data),
    .wr_en     (MEM_WB_RegWrite),
    .wr_addr   (MEM_WB_WriteReg),
    .wr_data   (MEM_WB_WriteData)
  );

  // A taken branch squashes the instruction anyway, so it masks the load-use stall.
  assign stall  = !EX_MEM_PCSrc && ID_EX_M[M_MEMREAD] && (ID_EX_rt != 5'd0) &&
                  ((ID_EX_rt == rs) || (ID_EX_rt == rt));
  assign bubble = stall || EX_MEM_PCSrc;

  always_ff @(posedge clock) begin
    if (!reset) begin
      ID_EX_NPC <= '0;
      ID_EX_A   <= '0;
      ID_EX_B   <= '0;
      ID_EX_Imm <= '0;
      ID_EX_rt  <= '0;
      ID_EX_rd  <= '0;
      ID_EX_WB  <= '0;
      ID_EX_M   <= '0;
      ID_EX_EX  <= '0;
    end else begin
      ID_EX_NPC <= IF_ID_NPC;
      ID_EX_A   <= rs_data;
      ID_EX_B   <= rt_data;
      ID_EX_Imm <= imm_ext;
      ID_EX_rt  <= rt;
      ID_EX_rd  <= rd;
      ID_EX_WB  <= bubble ? '0 : dec_ctrl.wb;
      ID_EX_M   <= bubble ? '0 : dec_ctrl.m;
      ID_EX_EX  <= bubble ? '0 : dec_ctrl.ex;
    end
  end

endmodule

// File: tb/tb_i_decode.sv
// Scoreboard bench for i_decode: an independent model predicts each ID/EX load and the stall flag.
// Honours I_DECODE_WB_BYPASS_EN so the same bench covers both register-file read behaviours.
module tb_i_decode;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] IF_ID_IR, IF_ID_NPC;
  logic        EX_MEM_PCSrc, MEM_WB_RegWrite;
  logic [4:0]  MEM_WB_WriteReg;
  logic [31:0] MEM_WB_WriteData;
  logic [31:0] ID_EX_NPC, ID_EX_A, ID_EX_B, ID_EX_Imm;
  logic [4:0]  ID_EX_rt, ID_EX_rd;
  logic [1:0]  ID_EX_WB;
  logic [2:0]  ID_EX_M;
  logic [3:0]  ID_EX_EX;
  logic        stall;

  always #5 clock = ~clock;

  i_decode #(.DATA_W(32)) dut (
    .clock(clock), .reset(reset), .IF_ID_IR(IF_ID_IR), .IF_ID_NPC(IF_ID_NPC),
    .EX_MEM_PCSrc(EX_MEM_PCSrc), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .MEM_WB_WriteReg(MEM_WB_WriteReg), .MEM_WB_WriteData(MEM_WB_WriteData),
    .ID_EX_NPC(ID_EX_NPC), .ID_EX_A(ID_EX_A), .ID_EX_B(ID_EX_B), .ID_EX_Imm(ID_EX_Imm),
    .ID_EX_rt(ID_EX_rt), .ID_EX_rd(ID_EX_rd), .ID_EX_WB(ID_EX_WB), .ID_EX_M(ID_EX_M),
    .ID_EX_EX(ID_EX_EX), .stall(stall)
  );

  typedef struct {
    logic [31:0] npc, a, b, imm;
    logic [4:0]  rt, rd;
    logic [8:0]  ctrl;
    logic        reset_cycle;
    logic        bubbled;
  } exp_t;

  exp_t        scoreboard[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] mregs [32];
  logic [2:0]  prev_m;
  logic [4:0]  prev_rt;

  // {WB[1:0], M[2:0], EX[3:0]}
  function automatic logic [8:0] model_ctrl(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b10_000_1100;
      6'h23:   return 9'b11_010_0001;
      6'h2B:   return 9'b00_001_0001;
      6'h04:   return 9'b00_100_0010;
      default: return 9'b00_000_0000;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx, input logic we,
                                             input logic [4:0] wreg, input logic [31:0] wdata);
    if (idx == 5'd0) return 32'd0;
`ifdef I_DECODE_WB_BYPASS_EN
    if (we && wreg == idx) return wdata;
`endif
    return mregs[idx];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One ID-stage cycle: drive at negedge, predict, then compare the ID/EX load after the edge.
  task automatic applyStimulus(input logic rst_n, input logic [31:0] ir, input logic [31:0] npc,
                               input logic pcsrc, input logic we, input logic [4:0] wreg,
                               input logic [31:0] wdata);
    exp_t       e, got;
    logic       exp_stall;
    logic [4:0] rs, rt;
    @(negedge clock);
    reset = rst_n; IF_ID_IR = ir; IF_ID_NPC = npc; EX_MEM_PCSrc = pcsrc;
    MEM_WB_RegWrite = we; MEM_WB_WriteReg = wreg; MEM_WB_WriteData = wdata;
    #1;
    rs = ir[25:21];
    rt = ir[20:16];
    exp_stall = prev_m[1] && (prev_rt != 5'd0) && ((prev_rt == rs) || (prev_rt == rt)) && !pcsrc;
    checkOutput("stall", {31'd0, stall}, {31'd0, exp_stall});
    e.reset_cycle = !rst_n;
    e.bubbled     = exp_stall || pcsrc;
    e.npc  = rst_n ? npc : 32'd0;
    e.a    = rst_n ? model_read(rs, we, wreg, wdata) : 32'd0;
    e.b    = rst_n ? model_read(rt, we, wreg, wdata) : 32'd0;
    e.imm  = rst_n ? {{16{ir[15]}}, ir[15:0]} : 32'd0;
    e.rt   = rst_n ? rt : 5'd0;
    e.rd   = rst_n ? ir[15:11] : 5'd0;
    e.ctrl = (!rst_n || exp_stall || pcsrc) ? 9'd0 : model_ctrl(ir[31:26]);
    scoreboard.push_back(e);
    @(posedge clock);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    end else if (we && wreg != 5'd0) begin
      mregs[wreg] = wdata;
    end
    #1;
    got = scoreboard.pop_front();
    checkOutput("ctrl", {23'd0, ID_EX_WB, ID_EX_M, ID_EX_EX}, {23'd0, got.ctrl});
    if (got.reset_cycle || !got.bubbled) begin
      checkOutput("npc", ID_EX_NPC, got.npc);
      checkOutput("A",   ID_EX_A,   got.a);
      checkOutput("B",   ID_EX_B,   got.b);
      checkOutput("imm", ID_EX_Imm, got.imm);
      checkOutput("rt",  {27'd0, ID_EX_rt}, {27'd0, got.rt});
      checkOutput("rd",  {27'd0, ID_EX_rd}, {27'd0, got.rd});
    end
    prev_m  = got.ctrl[6:4];
    prev_rt = got.rt;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [5:0]  op;
    logic [31:0] ir;
    reset = 1'b0; IF_ID_IR = 32'h8C220004; IF_ID_NPC = 32'd0; EX_MEM_PCSrc = 1'b0;
    MEM_WB_RegWrite = 1'b0; MEM_WB_WriteReg = 5'd0; MEM_WB_WriteData = 32'd0;
    @(posedge clock);
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    prev_m = 3'd0; prev_rt = 5'd0;

    applyStimulus(1'b0, 32'h8C220004, 32'h10, 1'b0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b0, 32'h8C220004, 32'h10, 1'b0, 1'b0, 5'd0, 32'd0);

    applyStimulus(1'b1, 32'hFC000000, 32'h4, 1'b0, 1'b1, 5'd1, 32'h100);
    applyStimulus(1'b1, 32'hFC000000, 32'h8, 1'b0, 1'b1, 5'd2, 32'h55);
    applyStimulus(1'b1, 32'hFC000000, 32'hC, 1'b0, 1'b1, 5'd3, 32'h7);
    applyStimulus(1'b1, 32'hFC000000, 32'hC, 1'b0, 1'b1, 5'd5, 32'h1234);

    applyStimulus(1'b1, 32'h8C220004, 32'h10, 1'b0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, 32'h00432020, 32'h14, 1'b0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, 32'h00432020, 32'h14, 1'b0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, 32'hAC43FFFC, 32'h18, 1'b0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, 32'h10220003, 32'h1C, 1'b0, 1'b0, 5'd0, 32'd0);

    applyStimulus(1'b1, 32'h8C220004, 32'h20, 1'b0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, 32'h00432020, 32'h24, 1'b1, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, 32'h00432020, 32'h40, 1'b0, 1'b0, 5'd0, 32'd0);

    applyStimulus(1'b1, 32'h00A03020, 32'h44, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
    applyStimulus(1'b1, 32'h00A03020, 32'h48, 1'b0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1'b1, 32'h00003020, 32'h4C, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
    applyStimulus(1'b1, 32'h00003020, 32'h50, 1'b0, 1'b0, 5'd0, 32'd0);

    applyStimulus(1'b1, 32'hFC000000, 32'h54, 1'b0, 1'b1, 5'd7, 32'h77);
    applyStimulus(1'b0, 32'hFC000000, 32'h58, 1'b0, 1'b1, 5'd7, 32'hAAAA);
    applyStimulus(1'b1, 32'h00E03020, 32'h5C, 1'b0, 1'b0, 5'd0, 32'd0);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0:       op = 6'h00;
        1:       op = 6'h23;
        2:       op = 6'h2B;
        3:       op = 6'h04;
        default: op = 6'($urandom_range(0, 63));
      endcase
      ir = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      applyStimulus(1'b1, ir, $urandom, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
